// File: rtl/alu_pkg.sv
// Shared ALU definitions: opcode encodings, the BIST op sequence and the
// operand LFSR step used by datapath checkers.
package alu_pkg;

  localparam int unsigned DATA_W  = 32;
  localparam int unsigned OP_W    = 3;
  localparam int unsigned IDX_W   = 16;
  localparam int unsigned NUM_OPS = 7;

  typedef enum logic [OP_W-1:0] {
    OP_AND  = 3'b000,
    OP_OR   = 3'b001,
    OP_ADD  = 3'b010,
    OP_SUB  = 3'b110,
    OP_ANDN = 3'b100,
    OP_ORN  = 3'b101,
    OP_SLT  = 3'b111
  } alu_op_t;

  // Vector k uses OP_TABLE[k mod 7]; 3'b011 is deliberately absent.
  localparam alu_op_t OP_TABLE [NUM_OPS] = '{
    OP_AND, OP_OR, OP_ADD, OP_SUB, OP_ANDN, OP_ORN, OP_SLT
  };

  localparam logic [DATA_W-1:0] LFSR_MASK = 32'h8020_0003;

  // Right-shifting Galois LFSR step.
  function automatic logic [DATA_W-1:0] lfsr_next(input logic [DATA_W-1:0] s);
    return (s >> 1) ^ (s[0] ? LFSR_MASK : '0);
  endfunction

endpackage

// File: rtl/alu_ref_model.sv
// Combinational golden model of the MIPS datapath ALU.
module alu_ref_model
  import alu_pkg::*;
(
  input  alu_op_t           op,
  input  logic [DATA_W-1:0] a,
  input  logic [DATA_W-1:0] b,
  output logic [DATA_W-1:0] exp_result,
  output logic              exp_zero
);

  always_comb begin
    exp_result = '0;
    case (op)
      OP_AND:  exp_result = a & b;
      OP_OR:   exp_result = a | b;
      OP_ADD:  exp_result = a + b;
      OP_SUB:  exp_result = a - b;
      OP_ANDN: exp_result = a & ~b;
      OP_ORN:  exp_result = a | ~b;
      OP_SLT:  exp_result = {{(DATA_W-1){1'b0}}, ($signed(a) < $signed(b))};
      default: exp_result = '0;
    endcase
    exp_zero = (exp_result == '0);
  end

endmodule

// File: rtl/alu_bist.sv
// Built-in self-test initiator: drives pseudo-random ALU vectors, checks the
// ALU response against alu_ref_model and reports pass/fail details.
module alu_bist
  import alu_pkg::*;
#(
  parameter int unsigned NUM_VECTORS = 256,
  parameter logic [31:0] SEED_A      = 32'hACE1_2025,
  parameter logic [31:0] SEED_B      = 32'h1357_9BDF
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  output logic              busy,
  output logic              done,
  output logic              pass,
  output logic [IDX_W-1:0]  err_count,
  output logic [IDX_W-1:0]  first_fail_idx,
  output logic [OP_W-1:0]   first_fail_op,
  output logic [OP_W-1:0]   ALUcontrol,
  output logic [DATA_W-1:0] SrcA,
  output logic [DATA_W-1:0] SrcB,
  input  logic [DATA_W-1:0] ALUresult,
  input  logic              zero
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_DRIVE = 2'd1,
    S_CHECK = 2'd2,
    S_DONE  = 2'd3
  } state_t;

  localparam logic [IDX_W-1:0] LAST_IDX     = IDX_W'(NUM_VECTORS - 1);
  localparam logic [IDX_W-1:0] CORNER_LIMIT = IDX_W'(NUM_OPS);
  localparam logic [OP_W-1:0]  OP_IDX_LAST  = OP_W'(NUM_OPS - 1);
  localparam logic [IDX_W-1:0] ERR_MAX      = '1;

  state_t              state;
  logic [DATA_W-1:0]   lfsr_a;
  logic [DATA_W-1:0]   lfsr_b;
  logic [IDX_W-1:0]    vec_idx;
  logic [OP_W-1:0]     op_idx;

  logic [DATA_W-1:0]   exp_result_c;
  logic                exp_zero_c;
  logic                mismatch_c;
  logic [IDX_W-1:0]    err_inc_c;

  alu_ref_model u_ref (
    .op         (alu_op_t'(ALUcontrol)),
    .a          (SrcA),
    .b          (SrcB),
    .exp_result (exp_result_c),
    .exp_zero   (exp_zero_c)
  );

  // Case-equality so any X/Z coming back from the ALU is flagged.
  always_comb begin
    mismatch_c = (ALUresult !== exp_result_c) || (zero !== exp_zero_c);
    err_inc_c  = (err_count == ERR_MAX) ? err_count : err_count + 1'b1;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state          <= S_IDLE;
      lfsr_a         <= SEED_A;
      lfsr_b         <= SEED_B;
      vec_idx        <= '0;
      op_idx         <= '0;
      busy           <= 1'b0;
      done           <= 1'b0;
      pass           <= 1'b0;
      err_count      <= '0;
      first_fail_idx <= '0;
      first_fail_op  <= '0;
      ALUcontrol     <= '0;
      SrcA           <= '0;
      SrcB           <= '0;
    end else begin
      case (state)
        S_IDLE, S_DONE: begin
          if (start) begin
            state          <= S_DRIVE;
            busy           <= 1'b1;
            done           <= 1'b0;
            pass           <= 1'b0;
            err_count      <= '0;
            first_fail_idx <= '0;
            first_fail_op  <= '0;
            lfsr_a         <= SEED_A;
            lfsr_b         <= SEED_B;
            vec_idx        <= '0;
            op_idx         <= '0;
          end
        end
        S_DRIVE: begin
          // The first seven vectors use SrcB == SrcA to hit SUB/SLT corners.
          ALUcontrol <= OP_TABLE[op_idx];
          SrcA       <= lfsr_a;
          SrcB       <= (vec_idx < CORNER_LIMIT) ? lfsr_a : lfsr_b;
          lfsr_a     <= lfsr_next(lfsr_a);
          lfsr_b     <= lfsr_next(lfsr_b);
          state      <= S_CHECK;
        end
        S_CHECK: begin
          if (mismatch_c) begin
            err_count <= err_inc_c;
            if (err_count == '0) begin
              first_fail_idx <= vec_idx;
              first_fail_op  <= ALUcontrol;
            end
          end
          if (vec_idx == LAST_IDX) begin
            state <= S_DONE;
            busy  <= 1'b0;
            done  <= 1'b1;
            pass  <= (err_count == '0) && !mismatch_c;
          end else begin
            vec_idx <= vec_idx + 1'b1;
            op_idx  <= (op_idx == OP_IDX_LAST) ? '0 : op_idx + 1'b1;
            state   <= S_DRIVE;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_alu_bist.sv
// Self-checking bench for alu_bist: a behavioural ALU with selectable faults
// feeds two DUT instances, and a vector-level reference predicts every result.
module tb_alu_bist;

  localparam int unsigned NV16   = 16;
  localparam int unsigned NV256  = 256;
  localparam logic [31:0] SEED_A = 32'hACE1_2025;
  localparam logic [31:0] SEED_B = 32'h1357_9BDF;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        reset, start16, start256;
  int unsigned fault_mode;
  int          checks   = 0;
  int          failures = 0;

  logic        busy16, done16, pass16, z16;
  logic [15:0] err16, ffi16;
  logic [2:0]  ffo16, ctl16;
  logic [31:0] a16, b16, res16;

  logic        busy256, done256, pass256, z256;
  logic [15:0] err256, ffi256;
  logic [2:0]  ffo256, ctl256;
  logic [31:0] a256, b256, res256;

  logic [2:0]  ops [7] = '{3'b000, 3'b001, 3'b010, 3'b110, 3'b100, 3'b101, 3'b111};
  logic [2:0]  exp_op [NV256];
  logic [31:0] exp_a  [NV256];
  logic [31:0] exp_b  [NV256];

  alu_bist #(.NUM_VECTORS(NV16), .SEED_A(SEED_A), .SEED_B(SEED_B)) u_dut16 (
    .clk(clk), .reset(reset), .start(start16), .busy(busy16), .done(done16),
    .pass(pass16), .err_count(err16), .first_fail_idx(ffi16),
    .first_fail_op(ffo16), .ALUcontrol(ctl16), .SrcA(a16), .SrcB(b16),
    .ALUresult(res16), .zero(z16)
  );

  alu_bist #(.NUM_VECTORS(NV256), .SEED_A(SEED_A), .SEED_B(SEED_B)) u_dut256 (
    .clk(clk), .reset(reset), .start(start256), .busy(busy256), .done(done256),
    .pass(pass256), .err_count(err256), .first_fail_idx(ffi256),
    .first_fail_op(ffo256), .ALUcontrol(ctl256), .SrcA(a256), .SrcB(b256),
    .ALUresult(res256), .zero(z256)
  );

  // Ideal ALU result and zero flag, packed as {zero, result}.
  function automatic logic [32:0] golden(input logic [2:0] op, input logic [31:0] a,
                                         input logic [31:0] b);
    logic [31:0] r;
    case (op)
      3'b000:  r = a & b;
      3'b001:  r = a | b;
      3'b010:  r = a + b;
      3'b110:  r = a - b;
      3'b100:  r = a & ~b;
      3'b101:  r = a | ~b;
      3'b111:  r = (int'(a) < int'(b)) ? 32'd1 : 32'd0;
      default: r = 32'd0;
    endcase
    return {(r == 32'd0), r};
  endfunction

  // ALU stand-in: 1 ADD bit0 stuck-1, 2 zero inverted, 3 unsigned SLT, 4 SUB drives X.
  function automatic logic [32:0] stub(input logic [2:0] op, input logic [31:0] a,
                                       input logic [31:0] b, input int unsigned mode);
    logic [32:0] g;
    logic [31:0] r;
    logic        z;
    g = golden(op, a, b);
    r = g[31:0];
    if (mode == 1 && op == 3'b010) r[0] = 1'b1;
    if (mode == 3 && op == 3'b111) r = (a < b) ? 32'd1 : 32'd0;
    if (mode == 4 && op == 3'b110) return {1'bx, 32'hxxxx_xxxx};
    z = (r == 32'd0);
    if (mode == 2) z = ~z;
    return {z, r};
  endfunction

  always_comb {z16, res16}   = stub(ctl16, a16, b16, fault_mode);
  always_comb {z256, res256} = stub(ctl256, a256, b256, fault_mode);

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Expected stream and run outcome for nv vectors under a given ALU fault.
  task automatic model_run(input int unsigned nv, input int unsigned mode,
                           output int exp_err, output logic [15:0] exp_ffi,
                           output logic [2:0] exp_ffo);
    logic [31:0] la, lb;
    la = SEED_A;
    lb = SEED_B;
    exp_err = 0;
    exp_ffi = '0;
    exp_ffo = '0;
    for (int k = 0; k < int'(nv); k++) begin
      exp_op[k] = ops[k % 7];
      exp_a[k]  = la;
      exp_b[k]  = (k < 7) ? la : lb;
      if (stub(exp_op[k], exp_a[k], exp_b[k], mode) !== golden(exp_op[k], exp_a[k], exp_b[k])) begin
        if (exp_err == 0) begin
          exp_ffi = 16'(k);
          exp_ffo = exp_op[k];
        end
        exp_err++;
      end
      la = (la >> 1) ^ (la[0] ? 32'h8020_0003 : 32'h0);
      lb = (lb >> 1) ^ (lb[0] ? 32'h8020_0003 : 32'h0);
    end
  endtask

  // Full 16-vector run with per-vector stimulus checks; hold keeps start high.
  task automatic run16(input int unsigned mode, input bit hold);
    int          e_err;
    logic [15:0] e_ffi;
    logic [2:0]  e_ffo;
    fault_mode = mode;
    model_run(NV16, mode, e_err, e_ffi, e_ffo);
    @(negedge clk);
    start16 = 1'b1;
    @(posedge clk);
    #1;
    if (!hold) start16 = 1'b0;
    @(negedge clk);
    chk("busy_after_start", 64'(busy16), 64'(1'b1));
    for (int k = 0; k < int'(NV16); k++) begin
      @(posedge clk);
      @(negedge clk);
      chk($sformatf("op[%0d]", k), 64'(ctl16), 64'(exp_op[k]));
      chk($sformatf("srca[%0d]", k), 64'(a16), 64'(exp_a[k]));
      chk($sformatf("srcb[%0d]", k), 64'(b16), 64'(exp_b[k]));
      if (k == int'(NV16) - 1) chk("done_early", 64'(done16), 64'(1'b0));
      @(posedge clk);
    end
    @(negedge clk);
    chk("done_at_2n", 64'(done16), 64'(1'b1));
    chk("busy_at_2n", 64'(busy16), 64'(1'b0));
    chk("pass16", 64'(pass16), 64'(e_err == 0));
    chk("err16", 64'(err16), 64'(e_err));
    chk("ffi16", 64'(ffi16), 64'(e_ffi));
    chk("ffo16", 64'(ffo16), 64'(e_ffo));
  endtask

  // 256-vector run observed only at its boundaries, with a bounded wait.
  task automatic run256(input int unsigned mode);
    int          e_err, cycles;
    logic [15:0] e_ffi;
    logic [2:0]  e_ffo;
    fault_mode = mode;
    model_run(NV256, mode, e_err, e_ffi, e_ffo);
    @(negedge clk);
    start256 = 1'b1;
    @(posedge clk);
    #1;
    start256 = 1'b0;
    cycles = 0;
    while (cycles < 2 * int'(NV256) + 20) begin
      @(posedge clk);
      #1;
      cycles++;
      if (done256) break;
    end
    chk("cycles256", 64'(cycles), 64'(2 * NV256));
    chk("pass256", 64'(pass256), 64'(e_err == 0));
    chk("err256", 64'(err256), 64'(e_err));
    chk("ffi256", 64'(ffi256), 64'(e_ffi));
    chk("ffo256", 64'(ffo256), 64'(e_ffo));
  endtask

  task automatic chk_reset16(input string tag);
    chk({tag, "_busy"}, 64'(busy16), 64'(1'b0));
    chk({tag, "_done"}, 64'(done16), 64'(1'b0));
    chk({tag, "_pass"}, 64'(pass16), 64'(1'b0));
    chk({tag, "_err"}, 64'(err16), 64'(0));
    chk({tag, "_ffi"}, 64'(ffi16), 64'(0));
    chk({tag, "_ffo"}, 64'(ffo16), 64'(0));
    chk({tag, "_ctl"}, 64'(ctl16), 64'(0));
    chk({tag, "_srca"}, 64'(a16), 64'(0));
    chk({tag, "_srcb"}, 64'(b16), 64'(0));
  endtask

  initial begin
    reset      = 1'b1;
    start16    = 1'b0;
    start256   = 1'b0;
    fault_mode = 0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk_reset16("por");
    chk("por_busy256", 64'(busy256), 64'(1'b0));
    reset = 1'b0;

    run16(0, 1'b0);
    repeat ($urandom_range(0, 3)) @(posedge clk);
    run16(1, 1'b0);
    run16(4, 1'b0);

    // start held high: ignored while busy, restarts right after done.
    run16(2, 1'b1);
    @(posedge clk);
    @(negedge clk);
    chk("held_restart_busy", 64'(busy16), 64'(1'b1));
    chk("held_restart_done", 64'(done16), 64'(1'b0));
    chk("held_restart_err", 64'(err16), 64'(0));
    start16 = 1'b0;
    reset   = 1'b1;
    @(posedge clk);
    #1;
    reset = 1'b0;

    // Abort during vector 5, then a clean rerun must reproduce the stream.
    fault_mode = 1;
    @(negedge clk);
    start16 = 1'b1;
    @(posedge clk);
    #1;
    start16 = 1'b0;
    repeat (1 + 2 * 5) @(posedge clk);
    @(negedge clk);
    reset = 1'b1;
    @(posedge clk);
    @(negedge clk);
    chk_reset16("abort");
    reset = 1'b0;
    run16(0, 1'b0);

    // start coincident with reset is ignored.
    @(negedge clk);
    reset   = 1'b1;
    start16 = 1'b1;
    @(posedge clk);
    @(negedge clk);
    chk("rst_start_busy", 64'(busy16), 64'(1'b0));
    reset   = 1'b0;
    start16 = 1'b0;

    run256(3);
    run256(0);
    for (int i = 0; i < 3; i++) begin
      repeat ($urandom_range(0, 4)) @(posedge clk);
      run16($urandom_range(0, 4), 1'b0);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
